// File: rtl/mem_bus_pkg.sv
// Shared types for the 16-bit address/data memory bus and the responder read pipeline.
package mem_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam data_t POISON = 16'hDEAD;

  typedef struct packed {
    logic  valid;
    data_t data;
  } rd_stage_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line: RD_LATENCY stages, one per clock, no stall.
// kill_i[i] discards the read held in stage i; async active-low clear empties every stage.
module mem_rd_pipe
  import mem_bus_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  rd_stage_t             in_i,
  input  logic [RD_LATENCY-1:0] kill_i,
  output rd_stage_t             tail_o,
  output logic                  tail_live_o
);

  rd_stage_t stage_q [RD_LATENCY];
  rd_stage_t stage_d [RD_LATENCY];

  always_comb begin
    stage_d[0] = in_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_d[i]       = stage_q[i-1];
      stage_d[i].valid = stage_q[i-1].valid & ~kill_i[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Raw tail lets the owner see a read that is being discarded this cycle.
  assign tail_o      = stage_q[RD_LATENCY-1];
  assign tail_live_o = stage_q[RD_LATENCY-1].valid & ~kill_i[RD_LATENCY-1];

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder on the shared tri-state bus: array writes, pipelined reads,
// out-of-range pulse and a saturating protocol-violation counter.
module memory_responder #(
  parameter int                ADDR_W     = mem_bus_pkg::ADDR_W,
  parameter int                DATA_W     = mem_bus_pkg::DATA_W,
  parameter int                DEPTH      = 256,
  parameter int                RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] POISON     = DATA_W'(mem_bus_pkg::POISON)
) (
  input  logic              clk,
  input  logic              reset_n,
  inout  wire  [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  output logic              rd_drive,
  output logic              oob_err,
  output logic [7:0]        collision_cnt
);
  import mem_bus_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("memory_responder: RD_LATENCY must be in 1..4");
  end
  if (DATA_W != mem_bus_pkg::DATA_W) begin : g_bad_width
    $error("memory_responder: DATA_W must match the bus package width");
  end

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  rd_stage_t             issue_stage;
  rd_stage_t             tail;
  logic                  tail_live;
  logic                  tail_collide;
  logic [RD_LATENCY-1:0] kill;
  logic                  oob_q, oob_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            cnt_inc;
  logic [8:0]            cnt_sum;

  assign in_range = (32'(addr) < 32'(DEPTH));
  assign idx      = addr[IDX_W-1:0];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset_n && wr && in_range) begin
      mem_q[idx] <= data;
    end
  end

  always_comb begin
    issue_stage.valid = rd & ~wr;
    issue_stage.data  = in_range ? mem_q[idx] : POISON;
  end

  // A write arriving in a drive cycle owns the bus; the returning read is lost.
  always_comb begin
    kill               = '0;
    kill[RD_LATENCY-1] = wr;
  end

  mem_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .in_i        (issue_stage),
    .kill_i      (kill),
    .tail_o      (tail),
    .tail_live_o (tail_live)
  );

  assign tail_collide = tail.valid & wr;
  assign rd_drive     = tail_live;
  assign data         = rd_drive ? tail.data : {DATA_W{1'bz}};

  always_comb begin
    oob_d   = (rd | wr) & ~in_range;
    cnt_inc = {1'b0, rd & wr} + {1'b0, tail_collide};
    cnt_sum = {1'b0, cnt_q} + {7'b0, cnt_inc};
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oob_q <= 1'b0;
      cnt_q <= 8'h00;
    end else begin
      oob_q <= oob_d;
      cnt_q <= cnt_d;
    end
  end

  assign oob_err       = oob_q;
  assign collision_cnt = cnt_q;

endmodule
